// File: rtl/msk_tx_framer.sv
// Transmit frame sequencer for msk_mod: preamble, sync word, MSB-first payload
// and zero tail, each bit held for SPS clocks with no gaps between bits.
module msk_tx_framer #(
    parameter int              SPS              = 20,
    parameter int              PREAMBLE_BYTES   = 4,
    parameter logic [7:0]      PREAMBLE_PATTERN = 8'hAA,
    parameter logic [15:0]     SYNC_WORD        = 16'h1ACF,
    parameter int              TAIL_BITS        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic        tx_bit,
    output logic        tx_active,
    output logic        bit_strobe,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam int SW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int PW = (PREAMBLE_BYTES > 1) ? $clog2(PREAMBLE_BYTES) : 1;
    localparam int TW = (TAIL_BITS > 1) ? $clog2(TAIL_BITS) : 1;

    localparam logic [SW-1:0] SAMP_LAST = SW'(SPS - 1);
    localparam logic [PW-1:0] BYTE_LAST = PW'(PREAMBLE_BYTES - 1);
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_BITS - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SYNC     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD  = 3'd3;
    localparam logic [2:0] ST_TAIL     = 3'd4;

    logic [2:0]    r_state;
    logic [SW-1:0] r_samp_cnt;
    logic [3:0]    r_bit_cnt;
    logic [PW-1:0] r_byte_cnt;
    logic [TW-1:0] r_tail_cnt;
    logic [15:0]   r_shreg;
    logic          r_last;
    logic          r_tx_bit;
    logic          r_tx_active;
    logic          r_bit_strobe;
    logic          r_frame_done;
    logic          r_underrun;
    logic [15:0]   r_frame_cnt;

    logic          w_boundary;
    logic          w_load_pt;
    logic [2:0]    w_state_nxt;
    logic [SW-1:0] w_samp_nxt;
    logic [3:0]    w_bit_nxt;
    logic [PW-1:0] w_byte_nxt;
    logic [TW-1:0] w_tail_nxt;
    logic [15:0]   w_shreg_nxt;
    logic          w_last_nxt;
    logic          w_done_nxt;
    logic          w_under_nxt;
    logic [15:0]   w_cnt_nxt;
    logic          w_active_nxt;

    // The shift register is 16 bits wide so the sync word is just another load;
    // preamble and payload bytes occupy the upper half and shift out of bit 15.
    assign w_boundary = (r_samp_cnt == SAMP_LAST);
    assign w_load_pt  = w_boundary &&
                        (((r_state == ST_SYNC) && (r_bit_cnt == 4'd15)) ||
                         ((r_state == ST_PAYLOAD) && (r_bit_cnt == 4'd7) && !r_last));
    assign s_tready   = w_load_pt;

    // Next-state, counter and shift-register logic.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_byte_nxt  = r_byte_cnt;
        w_tail_nxt  = r_tail_cnt;
        w_shreg_nxt = r_shreg;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        w_under_nxt = 1'b0;
        w_cnt_nxt   = r_frame_cnt;

        if ((r_state == ST_IDLE) || w_boundary) begin
            w_samp_nxt = {SW{1'b0}};
        end else begin
            w_samp_nxt = r_samp_cnt + SW'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (en && s_tvalid) begin
                    w_state_nxt = ST_PREAMBLE;
                    w_shreg_nxt = {PREAMBLE_PATTERN, 8'h00};
                    w_bit_nxt   = 4'd0;
                    w_byte_nxt  = {PW{1'b0}};
                end else begin
                    w_shreg_nxt = 16'h0000;
                end
            end
            ST_PREAMBLE: begin
                if (w_boundary && (r_bit_cnt == 4'd7)) begin
                    w_bit_nxt = 4'd0;
                    if (r_byte_cnt == BYTE_LAST) begin
                        w_state_nxt = ST_SYNC;
                        w_byte_nxt  = {PW{1'b0}};
                        w_shreg_nxt = SYNC_WORD;
                    end else begin
                        w_byte_nxt  = r_byte_cnt + PW'(1);
                        w_shreg_nxt = {PREAMBLE_PATTERN, 8'h00};
                    end
                end else if (w_boundary) begin
                    w_bit_nxt   = r_bit_cnt + 4'd1;
                    w_shreg_nxt = {r_shreg[14:0], 1'b0};
                end else begin
                    w_bit_nxt = r_bit_cnt;
                end
            end
            ST_SYNC, ST_PAYLOAD: begin
                if (w_boundary && (r_state == ST_PAYLOAD) && (r_bit_cnt == 4'd7) && r_last) begin
                    w_state_nxt = ST_TAIL;
                    w_bit_nxt   = 4'd0;
                    w_tail_nxt  = {TW{1'b0}};
                    w_shreg_nxt = 16'h0000;
                end else if (w_load_pt) begin
                    w_bit_nxt = 4'd0;
                    if (s_tvalid) begin
                        w_state_nxt = ST_PAYLOAD;
                        w_shreg_nxt = {s_tdata, 8'h00};
                        w_last_nxt  = s_tlast;
                    end else begin
                        // Source ran dry at a byte boundary: abandon the frame.
                        w_state_nxt = ST_IDLE;
                        w_shreg_nxt = 16'h0000;
                        w_under_nxt = 1'b1;
                    end
                end else if (w_boundary) begin
                    w_bit_nxt   = r_bit_cnt + 4'd1;
                    w_shreg_nxt = {r_shreg[14:0], 1'b0};
                end else begin
                    w_bit_nxt = r_bit_cnt;
                end
            end
            ST_TAIL: begin
                if (w_boundary && (r_tail_cnt == TAIL_LAST)) begin
                    w_state_nxt = ST_IDLE;
                    w_tail_nxt  = {TW{1'b0}};
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = r_frame_cnt + 16'd1;
                end else if (w_boundary) begin
                    w_tail_nxt = r_tail_cnt + TW'(1);
                end else begin
                    w_tail_nxt = r_tail_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_shreg_nxt = 16'h0000;
            end
        endcase

        w_active_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_samp_cnt   <= {SW{1'b0}};
            r_bit_cnt    <= 4'd0;
            r_byte_cnt   <= {PW{1'b0}};
            r_tail_cnt   <= {TW{1'b0}};
            r_shreg      <= 16'h0000;
            r_last       <= 1'b0;
            r_tx_bit     <= 1'b0;
            r_tx_active  <= 1'b0;
            r_bit_strobe <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_frame_cnt  <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_samp_cnt   <= w_samp_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_byte_cnt   <= w_byte_nxt;
            r_tail_cnt   <= w_tail_nxt;
            r_shreg      <= w_shreg_nxt;
            r_last       <= w_last_nxt;
            r_tx_bit     <= w_active_nxt && w_shreg_nxt[15];
            r_tx_active  <= w_active_nxt;
            r_bit_strobe <= w_active_nxt && (w_samp_nxt == {SW{1'b0}});
            r_frame_done <= w_done_nxt;
            r_underrun   <= w_under_nxt;
            r_frame_cnt  <= w_cnt_nxt;
        end
    end

    assign tx_bit     = r_tx_bit;
    assign tx_active  = r_tx_active;
    assign bit_strobe = r_bit_strobe;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_msk_tx_framer.sv
// Directed bench for msk_tx_framer (SPS=20, 2 preamble bytes, 8 tail bits);
// cycle 0 is the cycle in which en && s_tvalid is first sampled.
module tb_msk_tx_framer;

    localparam int SPS = 20;
    localparam int PB  = 2;
    localparam int TB  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic        tx_bit;
    logic        tx_active;
    logic        bit_strobe;
    logic        frame_done;
    logic        underrun;
    logic [15:0] frame_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt;
    logic [7:0]  pay [0:7];
    logic [7:0]  pat_v  = 8'hAA;
    logic [15:0] sync_v = 16'h1ACF;
    int          ev_cyc;
    int          rdy_cyc;
    int          cnt_a;
    int          cnt_b;

    msk_tx_framer #(
        .SPS              (SPS),
        .PREAMBLE_BYTES   (PB),
        .PREAMBLE_PATTERN (8'hAA),
        .SYNC_WORD        (16'h1ACF),
        .TAIL_BITS        (TB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .bit_strobe (bit_strobe),
        .frame_done (frame_done),
        .underrun   (underrun),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, s_tready, tx_bit, tx_active, bit_strobe, frame_done, underrun, frame_cnt};
    endfunction

    // Runs one frame of n bytes from pay[]; with under=1 the source stops after n
    // bytes without tlast. Every cycle is compared against the ideal bit stream.
    task automatic run_frame(input string tag, input int n, input bit under, input bit drop_en,
                             output int ev, output int first_rdy);
        logic exp_bits [0:255];
        int   nb, end_c, idx, kmax, rdy_cnt;
        int   e_act, e_bit, e_stb, e_rdy, e_done, e_und, e_both;
        bit   pend, x_act, x_stb, x_bit, x_rdy, x_done, x_und;
        nb = 0;
        for (int p = 0; p < PB; p++)
            for (int j = 7; j >= 0; j--) begin exp_bits[nb] = pat_v[j]; nb++; end
        for (int j = 15; j >= 0; j--) begin exp_bits[nb] = sync_v[j]; nb++; end
        for (int b = 0; b < n; b++)
            for (int j = 7; j >= 0; j--) begin exp_bits[nb] = pay[b][j]; nb++; end
        if (!under)
            for (int t = 0; t < TB; t++) begin exp_bits[nb] = 1'b0; nb++; end
        end_c = nb * SPS;
        kmax  = under ? n : n - 1;

        en = 1'b1; s_tvalid = 1'b1; s_tdata = pay[0]; s_tlast = (n == 1) && !under;
        chk({tag, "_ready_c0"}, s_tready, 0);
        idx = 0; pend = 1'b0; ev = -1; first_rdy = -1; rdy_cnt = 0;
        e_act = 0; e_bit = 0; e_stb = 0; e_rdy = 0; e_done = 0; e_und = 0; e_both = 0;

        for (int c = 1; c <= end_c + 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (pend) idx++;
            pend = 1'b0;
            if (drop_en && c == 5) en = 1'b0;
            if (idx < n) begin
                s_tvalid = 1'b1; s_tdata = pay[idx]; s_tlast = (idx == n - 1) && !under;
            end else begin
                s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
            end
            x_act  = (c <= end_c);
            x_stb  = x_act && ((c - 1) % SPS == 0);
            x_bit  = x_act ? exp_bits[(c - 1) / SPS] : 1'b0;
            x_rdy  = (c % (8 * SPS) == 0) && (c >= (8 * PB + 16) * SPS) &&
                     (c <= (8 * PB + 16 + 8 * kmax) * SPS);
            x_done = !under && (c == end_c + 1);
            x_und  = under && (c == end_c + 1);
            if (tx_active  !== x_act)  e_act++;
            if (bit_strobe !== x_stb)  e_stb++;
            if (tx_bit     !== x_bit)  e_bit++;
            if (s_tready   !== x_rdy)  e_rdy++;
            if (frame_done !== x_done) e_done++;
            if (underrun   !== x_und)  e_und++;
            if (frame_done && underrun) e_both++;
            if (s_tready) begin
                rdy_cnt++;
                if (first_rdy < 0) first_rdy = c;
            end
            if ((frame_done || underrun) && ev < 0) ev = c;
            if (s_tready && s_tvalid) pend = 1'b1;
        end
        if (!under) exp_cnt = exp_cnt + 16'd1;

        chk({tag, "_active_err"},   e_act,   0);
        chk({tag, "_bit_err"},      e_bit,   0);
        chk({tag, "_strobe_err"},   e_stb,   0);
        chk({tag, "_ready_err"},    e_rdy,   0);
        chk({tag, "_done_err"},     e_done,  0);
        chk({tag, "_underrun_err"}, e_und,   0);
        chk({tag, "_excl"},         e_both,  0);
        chk({tag, "_ready_cnt"},    rdy_cnt, kmax + 1);
        chk({tag, "_frame_cnt"},    frame_cnt, exp_cnt);
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
        exp_cnt = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outs", outs(), 32'd0);

        // Single byte 33: AA AA 1A CF 33 00.
        pay[0] = 8'h33;
        run_frame("single", 1, 1'b0, 1'b0, ev_cyc, rdy_cyc);
        chk("single_ready_cyc", rdy_cyc, 640);
        chk("single_done_cyc",  ev_cyc,  961);
        chk("single_cnt",       frame_cnt, 16'd1);

        // Four bytes, source always valid; 72 bits -> 1440 active cycles.
        pay[0] = 8'h10; pay[1] = 8'h10; pay[2] = 8'h00; pay[3] = 8'hFF;
        run_frame("four", 4, 1'b0, 1'b0, ev_cyc, rdy_cyc);
        chk("four_ready_cyc", rdy_cyc, 640);
        chk("four_done_cyc",  ev_cyc,  1441);

        // Underrun after 5A: registered pulse coincides with tx_active dropping.
        pay[0] = 8'h5A;
        run_frame("under", 1, 1'b1, 1'b0, ev_cyc, rdy_cyc);
        chk("under_cyc", ev_cyc, 801);
        chk("under_cnt", frame_cnt, 16'd2);

        // en low holds off a pending source.
        en = 1'b0; s_tvalid = 1'b1; s_tdata = 8'hC3; s_tlast = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_active) cnt_a++;
            if (s_tready)  cnt_b++;
        end
        chk("en_low_active", cnt_a, 0);
        chk("en_low_ready",  cnt_b, 0);
        pay[0] = 8'hC3;
        run_frame("en_drop", 1, 1'b0, 1'b1, ev_cyc, rdy_cyc);
        chk("en_drop_done_cyc", ev_cyc, 961);

        // Asynchronous reset while idle clears the frame counter.
        chk("pre_rst_cnt", frame_cnt, 16'd3);
        #2 reset = 1'b1;
        #1 chk("rst_idle_outs", outs(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 16'h0000;

        // Asynchronous reset mid-frame aborts without done/underrun.
        @(negedge clk);
        en = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h33; s_tlast = 1'b1;
        repeat (100) @(negedge clk);
        chk("mid_active", tx_active, 1);
        s_tvalid = 1'b0;
        #2 reset = 1'b1;
        #1 chk("rst_frame_outs", outs(), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (outs() != 32'd0) cnt_a++;
        end
        chk("post_rst_quiet", cnt_a, 0);

        // Frame counter wraps FFFF -> 0000.
        force dut.r_frame_cnt = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.r_frame_cnt;
        @(negedge clk);
        chk("wrap_pre", frame_cnt, 16'hFFFF);
        exp_cnt = 16'hFFFF;
        pay[0] = 8'h81;
        run_frame("wrap", 1, 1'b0, 1'b0, ev_cyc, rdy_cyc);
        chk("wrap_cnt", frame_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
